// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad emulator and the row
// scanner it answers.
//   - one-cold row / column constants (active-low keypad lines)
//   - FSM state enum
//   - code_to_rc: key code -> (row, column) on the physical matrix
//   - row_decode: registered row pattern -> row index (or "no row")
//   - SCAN_ROW_DWELL: cycles the scanner holds each row low
package keypad_pkg;

    localparam logic [3:0] ROW0_N   = 4'b1110;
    localparam logic [3:0] ROW1_N   = 4'b1101;
    localparam logic [3:0] ROW2_N   = 4'b1011;
    localparam logic [3:0] ROW3_N   = 4'b0111;
    localparam logic [3:0] ROW_NONE = 4'b1111;

    localparam logic [3:0] COL0_N   = 4'b1110;
    localparam logic [3:0] COL1_N   = 4'b1101;
    localparam logic [3:0] COL2_N   = 4'b1011;
    localparam logic [3:0] COL3_N   = 4'b0111;
    localparam logic [3:0] COL_IDLE = 4'b1111;

    localparam int unsigned SCAN_ROW_DWELL = 250000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } rc_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } row_sel_t;

    // Matrix layout: row 0 = 7 4 1 0, row 1 = 8 5 2 A, row 2 = 9 6 3 B,
    // row 3 = C D E F.
    function automatic rc_t code_to_rc(input logic [3:0] code);
        rc_t rc;
        case (code)
            4'd7:    rc = '{row: 2'd0, col: 2'd0};
            4'd4:    rc = '{row: 2'd0, col: 2'd1};
            4'd1:    rc = '{row: 2'd0, col: 2'd2};
            4'd0:    rc = '{row: 2'd0, col: 2'd3};
            4'd8:    rc = '{row: 2'd1, col: 2'd0};
            4'd5:    rc = '{row: 2'd1, col: 2'd1};
            4'd2:    rc = '{row: 2'd1, col: 2'd2};
            4'd10:   rc = '{row: 2'd1, col: 2'd3};
            4'd9:    rc = '{row: 2'd2, col: 2'd0};
            4'd6:    rc = '{row: 2'd2, col: 2'd1};
            4'd3:    rc = '{row: 2'd2, col: 2'd2};
            4'd11:   rc = '{row: 2'd2, col: 2'd3};
            4'd12:   rc = '{row: 2'd3, col: 2'd0};
            4'd13:   rc = '{row: 2'd3, col: 2'd1};
            4'd14:   rc = '{row: 2'd3, col: 2'd2};
            default: rc = '{row: 2'd3, col: 2'd3};
        endcase
        return rc;
    endfunction

    // Only a single low row line selects a row; idle (1111) and multi-low
    // patterns are treated as "no row".
    function automatic row_sel_t row_decode(input logic [3:0] row_n);
        row_sel_t s;
        s.valid = 1'b1;
        s.idx   = 2'd0;
        case (row_n)
            ROW0_N:  s.idx = 2'd0;
            ROW1_N:  s.idx = 2'd1;
            ROW2_N:  s.idx = 2'd2;
            ROW3_N:  s.idx = 2'd3;
            default: s.valid = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] col_pattern(input logic [1:0] col);
        logic [3:0] p;
        case (col)
            2'd0:    p = COL0_N;
            2'd1:    p = COL1_N;
            2'd2:    p = COL2_N;
            default: p = COL3_N;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: key-code push port of the keypad emulator.
//   key_valid  host -> emulator  a code is offered
//   key_code   host -> emulator  code 0..15
//   key_ready  emulator -> host  queue has room
// Handshake: a code transfers on every rising clock edge where key_valid
// and key_ready are both high. key_ready depends only on the queue fill,
// never on key_valid; a code offered while key_ready is low is not taken
// and the host must hold or re-offer it.
interface keypad_emulator_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_fifo.sv
// keypad_fifo: synchronous FIFO with fill level.
//   clk, reset      clock, asynchronous active-high reset
//   wr_en, wr_data  write request; ignored while full
//   rd_en, rd_data  read request; rd_data shows the head (valid when !empty)
//   full, empty     status
//   level           number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module keypad_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: answers a row-scanning keypad controller as if keys were
// pressed on a physical 4x4 matrix.
//   clk, reset   clock, asynchronous active-high reset
//   keypadrow    scanner row drive, active-low one-cold
//   keypadcol    column return, active-low (registered)
//   key_if       key-code push port (slave side)
//   busy         a key is in progress or codes are queued
//   key_done     one-cycle pulse on the last released cycle of each key
//   fifo_level   number of queued codes
//   dbg_state    current FSM state
// Each code is pressed for PRESS_SCANS visits of its row, then the lines
// stay released for GAP_CYCLES cycles (GAP_CYCLES must be >= 1,
// PRESS_SCANS >= 1).
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          PRESS_SCANS = 2,
    parameter logic [31:0] GAP_CYCLES  = 32'd500000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  keypadrow,
    output logic [3:0]                  keypadcol,
    keypad_emulator_if.slave            key_if,
    output logic                        busy,
    output logic                        key_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output state_t                      dbg_state
);
    localparam int VW = $clog2(PRESS_SCANS + 1);
    localparam logic [VW-1:0] VISITS_DONE = PRESS_SCANS[VW-1:0];

    state_t     state;
    logic [3:0] row_q;
    logic [1:0] tgt_row;
    logic [1:0] tgt_col;
    logic [VW-1:0] visit_cnt;
    logic       in_row;      // row_q matched the target on the previous cycle
    logic [31:0] gap_cnt;

    logic [3:0] head_code;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    rc_t        head_rc;
    row_sel_t   row_sel;
    logic       row_hit;

    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign head_rc   = code_to_rc(head_code);
    assign row_sel   = row_decode(row_q);
    assign row_hit   = row_sel.valid && (row_sel.idx == tgt_row);

    assign key_if.key_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign dbg_state = state;

    keypad_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (key_if.key_valid),
        .wr_data (key_if.key_code),
        .rd_en   (fifo_pop),
        .rd_data (head_code),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            row_q     <= ROW_NONE;
            keypadcol <= COL_IDLE;
            key_done  <= 1'b0;
            tgt_row   <= 2'd0;
            tgt_col   <= 2'd0;
            visit_cnt <= '0;
            in_row    <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            row_q     <= keypadrow;
            keypadcol <= COL_IDLE;
            key_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        tgt_row   <= head_rc.row;
                        tgt_col   <= head_rc.col;
                        visit_cnt <= '0;
                        // Cleared so a row already selected at entry counts
                        // as the first visit.
                        in_row    <= 1'b0;
                        state     <= PRESS;
                    end
                end
                PRESS: begin
                    if (row_hit) keypadcol <= col_pattern(tgt_col);
                    if (row_hit && !in_row) visit_cnt <= visit_cnt + 1'b1;
                    in_row <= row_hit;
                    if (!row_hit && (visit_cnt == VISITS_DONE)) begin
                        // gap_cnt counts down to 0 over GAP_CYCLES cycles;
                        // key_done is raised one step ahead so it lands on
                        // the final RELEASE cycle.
                        gap_cnt  <= GAP_CYCLES - 32'd1;
                        key_done <= (GAP_CYCLES == 32'd1);
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (gap_cnt == 32'd0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt  <= gap_cnt - 32'd1;
                        key_done <= (gap_cnt == 32'd1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;
    import keypad_pkg::*;

    localparam int          FIFO_DEPTH  = 4;
    localparam int          PRESS_SCANS = 2;
    localparam int          GAP         = 3000;

    logic       clk;
    logic       reset;
    logic [3:0] keypadrow;
    logic [3:0] keypadcol;
    logic       busy;
    logic       key_done;
    logic [2:0] fifo_level;
    state_t     dbg_state;

    keypad_emulator_if key_if ();

    keypad_emulator #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .PRESS_SCANS (PRESS_SCANS),
        .GAP_CYCLES  (32'd3000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .keypadrow  (keypadrow),
        .keypadcol  (keypadcol),
        .key_if     (key_if),
        .busy       (busy),
        .key_done   (key_done),
        .fifo_level (fifo_level),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Physical key layout; the model finds a code's position by searching it.
    int key_grid [4][4] = '{'{7, 4, 1, 0}, '{8, 5, 2, 10}, '{9, 6, 3, 11}, '{12, 13, 14, 15}};

    int         mq[$];          // queued codes
    int         m_mode;         // 0 idle, 1 pressing, 2 gap
    int         m_r, m_c;
    int         m_visits;
    bit         m_in;
    int         m_gap;          // release cycles remaining, including the current one
    logic [3:0] m_rowq;
    logic [3:0] e_col;
    logic       e_done;

    function automatic int row_of(input logic [3:0] r);
        if (r == 4'b1110) return 0;
        if (r == 4'b1101) return 1;
        if (r == 4'b1011) return 2;
        if (r == 4'b0111) return 3;
        return -1;
    endfunction

    task automatic model_step();
        bit         do_push;
        bit         hit;
        int         code;
        logic [3:0] one;
        one = 4'b0001;
        if (reset) begin
            mq.delete();
            m_mode = 0; m_visits = 0; m_in = 0; m_gap = 0;
            m_rowq = 4'hF; e_col = 4'hF; e_done = 1'b0;
            return;
        end
        do_push = key_if.key_valid && (mq.size() < FIFO_DEPTH);
        e_col = 4'hF;
        case (m_mode)
            0: if (mq.size() > 0) begin
                code = mq.pop_front();
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        if (key_grid[r][c] == code) begin m_r = r; m_c = c; end
                m_visits = 0; m_in = 0; m_mode = 1;
            end
            1: begin
                hit = (row_of(m_rowq) == m_r);
                if (hit) e_col = ~(one << m_c);
                if (hit && !m_in) m_visits++;
                m_in = hit;
                if (!hit && m_visits >= PRESS_SCANS) begin m_mode = 2; m_gap = GAP; end
            end
            default: begin
                m_gap--;
                if (m_gap == 0) m_mode = 0;
            end
        endcase
        if (do_push) mq.push_back(int'(key_if.key_code));
        m_rowq = keypadrow;
        e_done = (m_mode == 2) && (m_gap == 1);
    endtask

    // ---------------- scanner + per-cycle compare ----------------
    bit         scan_en = 0;
    int         dwell   = 50;
    int         scan_idx = 0;
    int         scan_cnt = 0;
    logic [7:0] win_q[$];       // {col, row} at the start of each column-low window
    logic [7:0] exp_q[$];
    logic [3:0] prev_col = 4'hF;
    int         done_cnt = 0;

    task automatic tick();
        logic [3:0] one;
        one = 4'b0001;
        @(posedge clk);
        model_step();
        #1;
        if (!reset) begin
            chk("keypadcol", 32'(keypadcol), 32'(e_col));
            chk("key_done", 32'(key_done), 32'(e_done));
            chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
            chk("key_ready", 32'(key_if.key_ready), 32'(mq.size() < FIFO_DEPTH));
            chk("busy", 32'(busy), 32'((m_mode != 0) || (mq.size() != 0)));
            if (prev_col == 4'hF && keypadcol != 4'hF) win_q.push_back({keypadcol, keypadrow});
            prev_col = keypadcol;
            if (key_done) done_cnt++;
        end else begin
            prev_col = 4'hF;
        end
        @(negedge clk);
        if (scan_en) begin
            scan_cnt++;
            if (scan_cnt >= dwell) begin scan_cnt = 0; scan_idx = (scan_idx + 1) % 4; end
            keypadrow = ~(one << scan_idx);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_row(input logic [3:0] r);
        scan_en = 0;
        keypadrow = r;
    endtask

    task automatic offer(input logic [3:0] code);
        key_if.key_valid = 1'b1;
        key_if.key_code  = code;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_wins(input string tag, input int base);
        chk({tag, "_windows"}, 32'(win_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < win_q.size()) chk({tag, "_window"}, 32'(win_q[base + i]), 32'(exp_q[i]));
    endtask

    // ---------------- directed tests ----------------
    int wbase, dbase;

    initial begin
        reset = 1'b1;
        key_if.key_valid = 1'b0;
        key_if.key_code  = 4'd0;
        keypadrow = 4'hF;
        ticks(3);
        reset = 1'b0;
        #1;
        chk("rst_col", 32'(keypadcol), 32'hF);
        chk("rst_ready", 32'(key_if.key_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(key_done), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        ticks(2);

        // Key 5 with a free-running scanner, 1000-cycle dwell.
        dwell = 1000; scan_en = 1;
        ticks(1500);
        wbase = win_q.size(); dbase = done_cnt;
        offer(4'd5);
        key_if.key_valid = 1'b0;
        wait_idle(20000);
        exp_q = '{8'hDD, 8'hDD};
        check_wins("t1", wbase);
        chk("t1_done", 32'(done_cnt - dbase), 32'd1);

        // 7, 0, 15 back to back; pins push->press latency and level steps.
        dwell = 50;
        wbase = win_q.size(); dbase = done_cnt;
        offer(4'd7);
        chk("t2_level_a", 32'(fifo_level), 32'd1);
        chk("t2_state_a", 32'(dbg_state), 32'(IDLE));
        offer(4'd0);
        chk("t2_level_b", 32'(fifo_level), 32'd1);
        chk("t2_state_b", 32'(dbg_state), 32'(PRESS));
        offer(4'd15);
        chk("t2_level_c", 32'(fifo_level), 32'd2);
        key_if.key_valid = 1'b0;
        wait_idle(15000);
        exp_q = '{8'hEE, 8'hEE, 8'h7E, 8'h7E, 8'h77, 8'h77};
        check_wins("t2", wbase);
        chk("t2_done", 32'(done_cnt - dbase), 32'd3);
        chk("t2_level_end", 32'(fifo_level), 32'd0);

        // Fill the queue with the scanner stalled; a sixth code is dropped.
        set_row(4'hF);
        wbase = win_q.size(); dbase = done_cnt;
        offer(4'd1); offer(4'd2); offer(4'd3); offer(4'd4); offer(4'd13);
        chk("t3_level_full", 32'(fifo_level), 32'd4);
        chk("t3_ready_full", 32'(key_if.key_ready), 32'd0);
        offer(4'd14);
        key_if.key_valid = 1'b0;
        chk("t3_level_drop", 32'(fifo_level), 32'd4);
        chk("t3_state_stall", 32'(dbg_state), 32'(PRESS));
        scan_en = 1;
        wait_idle(30000);
        exp_q = '{8'hBE, 8'hBE, 8'hBD, 8'hBD, 8'hBB, 8'hBB, 8'hDE, 8'hDE, 8'hD7, 8'hD7};
        check_wins("t3", wbase);
        chk("t3_done", 32'(done_cnt - dbase), 32'd5);

        // Key 8 with no valid row: stays pressed-but-silent.
        set_row(4'hF);
        offer(4'd8);
        key_if.key_valid = 1'b0;
        ticks(30);
        chk("t4_state_idle_row", 32'(dbg_state), 32'(PRESS));
        chk("t4_col_idle_row", 32'(keypadcol), 32'hF);
        set_row(4'b1100);
        ticks(30);
        chk("t4_state_multi_row", 32'(dbg_state), 32'(PRESS));
        chk("t4_col_multi_row", 32'(keypadcol), 32'hF);

        // Reset in the middle of pressing key 9 with two codes queued.
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        set_row(4'b1011);
        ticks(2);
        offer(4'd9); offer(4'd3); offer(4'd6);
        key_if.key_valid = 1'b0;
        ticks(10);
        chk("t5_col_pressed", 32'(keypadcol), 32'b1110);
        chk("t5_level_pre", 32'(fifo_level), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("t5_col_async", 32'(keypadcol), 32'hF);
        chk("t5_level_async", 32'(fifo_level), 32'd0);
        chk("t5_busy_async", 32'(busy), 32'd0);
        chk("t5_ready_async", 32'(key_if.key_ready), 32'd1);
        ticks(2);
        reset = 1'b0;
        set_row(4'hF);
        ticks(5);
        chk("t5_state_after", 32'(dbg_state), 32'(IDLE));
        chk("t5_busy_after", 32'(busy), 32'd0);

        // Key 10 with its row already selected at press entry.
        set_row(4'b1101);
        wbase = win_q.size(); dbase = done_cnt;
        offer(4'd10);
        key_if.key_valid = 1'b0;
        ticks(20);
        set_row(4'b1011);
        ticks(20);
        chk("t6_state_after_first", 32'(dbg_state), 32'(PRESS));
        set_row(4'b1101);
        ticks(20);
        set_row(4'hF);
        ticks(5);
        chk("t6_state_after_second", 32'(dbg_state), 32'(RELEASE));
        wait_idle(5000);
        exp_q = '{8'h7D, 8'h7D};
        check_wins("t6", wbase);
        chk("t6_done", 32'(done_cnt - dbase), 32'd1);

        ticks(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
